// File: rtl/action_decoder.sv
// action_decoder: translates strobed IR command bytes into a registered
// action code, control mode and speed level, with a hold watchdog that
// stops the car when the remote goes silent and a saturating counter of
// unrecognised command bytes.
module action_decoder #(
    parameter int HOLD_CYCLES   = 10_000_000,
    parameter int SPEED_LEVELS  = 4,
    parameter int SPEED_DEFAULT = 2,
    parameter int ERR_W         = 8,
    localparam int SPEED_W      = $clog2(SPEED_LEVELS)
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic [7:0]         frame_data,
    input  logic               frame_valid,
    input  logic               frame_repeat,
    output logic [3:0]         action,
    output logic [1:0]         mini_car_mode,
    output logic [SPEED_W-1:0] speed,
    output logic               action_valid,
    output logic               timeout,
    output logic [ERR_W-1:0]   err_cnt
);

    // Watchdog counter only needs to reach HOLD_CYCLES-1.
    localparam int WD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(HOLD_CYCLES - 1);
    localparam logic [SPEED_W-1:0] SPEED_MAX  = SPEED_W'(SPEED_LEVELS - 1);
    localparam logic [SPEED_W-1:0] SPEED_INIT = SPEED_W'(SPEED_DEFAULT);

    localparam logic [3:0] ACT_STRAIGHT  = 4'h2;
    localparam logic [3:0] ACT_TURN_L    = 4'h4;
    localparam logic [3:0] ACT_TURN_R    = 4'h5;
    localparam logic [3:0] ACT_STURN_L   = 4'h6;
    localparam logic [3:0] ACT_STURN_R   = 4'h7;
    localparam logic [3:0] ACT_REV_L     = 4'h8;
    localparam logic [3:0] ACT_REV_R     = 4'h9;
    localparam logic [3:0] ACT_RETREAT   = 4'hA;
    localparam logic [3:0] ACT_STOP      = 4'hF;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'b00,
        MODE_AUTO_A = 2'b01,
        MODE_AUTO_B = 2'b10,
        MODE_OFF    = 2'b11
    } mode_t;

    mode_t              mode_r,         mode_nxt;
    logic [3:0]         action_r,       action_nxt;
    logic [SPEED_W-1:0] speed_r,        speed_nxt;
    logic [ERR_W-1:0]   err_r,          err_nxt;
    logic [WD_W-1:0]    wd_r,           wd_nxt;
    logic               action_valid_r, action_valid_nxt;
    logic               timeout_r,      timeout_nxt;
    logic               manual;

    function automatic logic [SPEED_W-1:0] sat_speed_inc(input logic [SPEED_W-1:0] s);
        return (s >= SPEED_MAX) ? SPEED_MAX : s + 1'b1;
    endfunction

    function automatic logic [SPEED_W-1:0] sat_speed_dec(input logic [SPEED_W-1:0] s);
        return (s == '0) ? '0 : s - 1'b1;
    endfunction

    function automatic logic [ERR_W-1:0] sat_err_inc(input logic [ERR_W-1:0] e);
        return (&e) ? e : e + 1'b1;
    endfunction

    assign manual = (mode_r == MODE_MANUAL);

    // Next-state decode of the command byte plus watchdog bookkeeping.
    always_comb begin
        mode_nxt    = mode_r;
        action_nxt  = action_r;
        speed_nxt   = speed_r;
        err_nxt     = err_r;
        wd_nxt      = wd_r;
        timeout_nxt = 1'b0;

        if (frame_valid) begin
            case (frame_data)
                8'h45: begin
                    mode_nxt   = MODE_MANUAL;
                    action_nxt = ACT_STOP;
                    speed_nxt  = SPEED_INIT;
                end
                8'h47: action_nxt = ACT_STOP;
                8'h42: if (mode_r != MODE_OFF) begin
                    mode_nxt   = MODE_MANUAL;
                    action_nxt = ACT_STOP;
                end
                8'h52: if (mode_r != MODE_OFF) begin
                    mode_nxt   = MODE_AUTO_A;
                    action_nxt = ACT_STOP;
                end
                8'h4A: if (mode_r != MODE_OFF) begin
                    mode_nxt   = MODE_AUTO_B;
                    action_nxt = ACT_STOP;
                end
                8'h40: if (manual) action_nxt = ACT_STRAIGHT;
                8'h07: if (manual) action_nxt = ACT_TURN_L;
                8'h09: if (manual) action_nxt = ACT_TURN_R;
                8'h16: if (manual) action_nxt = ACT_STURN_L;
                8'h0D: if (manual) action_nxt = ACT_STURN_R;
                8'h43: if (manual) action_nxt = ACT_REV_L;
                8'h44: if (manual) action_nxt = ACT_REV_R;
                8'h19: if (manual) action_nxt = ACT_RETREAT;
                8'h15: if (manual) action_nxt = ACT_STOP;
                8'h0C: if (manual) speed_nxt = sat_speed_inc(speed_r);
                8'h18: if (manual) speed_nxt = sat_speed_dec(speed_r);
                default: err_nxt = sat_err_inc(err_r);
            endcase
        end

        // Any strobe refreshes the watchdog and pre-empts an expiry this cycle.
        if (frame_valid || frame_repeat) begin
            wd_nxt = '0;
        end else if (manual && (action_r != ACT_STOP)) begin
            if (wd_r == WD_LAST) begin
                wd_nxt      = '0;
                action_nxt  = ACT_STOP;
                timeout_nxt = 1'b1;
            end else begin
                wd_nxt = wd_r + 1'b1;
            end
        end else begin
            wd_nxt = '0;
        end

        action_valid_nxt = (action_nxt != action_r);
    end

    // State register; reset overrides any strobe in the same cycle.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            mode_r         <= MODE_OFF;
            action_r       <= ACT_STOP;
            speed_r        <= SPEED_INIT;
            err_r          <= '0;
            wd_r           <= '0;
            action_valid_r <= 1'b0;
            timeout_r      <= 1'b0;
        end else begin
            mode_r         <= mode_nxt;
            action_r       <= action_nxt;
            speed_r        <= speed_nxt;
            err_r          <= err_nxt;
            wd_r           <= wd_nxt;
            action_valid_r <= action_valid_nxt;
            timeout_r      <= timeout_nxt;
        end
    end

    assign action        = action_r;
    assign mini_car_mode = mode_r;
    assign speed         = speed_r;
    assign action_valid  = action_valid_r;
    assign timeout       = timeout_r;
    assign err_cnt       = err_r;

endmodule

// File: tb/tb_action_decoder.sv
// Directed testbench for action_decoder with HOLD_CYCLES = 16,
// SPEED_LEVELS = 4, SPEED_DEFAULT = 2.
module tb_action_decoder;

    localparam int HOLD = 16;

    logic       clk_in = 1'b0;
    logic       rst;
    logic [7:0] frame_data;
    logic       frame_valid;
    logic       frame_repeat;
    logic [3:0] action;
    logic [1:0] mini_car_mode;
    logic [1:0] speed;
    logic       action_valid;
    logic       timeout;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    action_decoder #(
        .HOLD_CYCLES  (HOLD),
        .SPEED_LEVELS (4),
        .SPEED_DEFAULT(2),
        .ERR_W        (8)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .frame_repeat (frame_repeat),
        .action       (action),
        .mini_car_mode(mini_car_mode),
        .speed        (speed),
        .action_valid (action_valid),
        .timeout      (timeout),
        .err_cnt      (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One-cycle frame_valid strobe carrying byte b.
    task automatic send(input logic [7:0] b);
        frame_data  = b;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        frame_data  = 8'hA5;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_valid = 1'b0;
        frame_repeat = 1'b0;
        frame_data = 8'h00;
        step();
        step();
        n_cmp++; if (action !== 4'hF) begin n_bad++; $display("FAIL reset_action: got %h want F", action); end
        n_cmp++; if (mini_car_mode !== 2'b11) begin n_bad++; $display("FAIL reset_mode: got %b want 11", mini_car_mode); end
        n_cmp++; if (speed !== 2'd2) begin n_bad++; $display("FAIL reset_speed: got %0d want 2", speed); end
        n_cmp++; if (action_valid !== 1'b0 || timeout !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got av=%b to=%b want 0 0", action_valid, timeout); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", err_cnt); end
        rst = 1'b0;
        step();
        // Off mode ignores mode-select and motion codes without counting errors.
        send(8'h42);
        send(8'h07);
        n_cmp++; if (mini_car_mode !== 2'b11 || action !== 4'hF || err_cnt !== 8'd0) begin n_bad++; $display("FAIL off_ignore: got mode=%b act=%h err=%0d want 11 F 0", mini_car_mode, action, err_cnt); end
    endtask

    task automatic test_power();
        send(8'h45);
        n_cmp++; if (mini_car_mode !== 2'b00 || action !== 4'hF || speed !== 2'd2) begin n_bad++; $display("FAIL power: got mode=%b act=%h spd=%0d want 00 F 2", mini_car_mode, action, speed); end
        n_cmp++; if (action_valid !== 1'b0) begin n_bad++; $display("FAIL power_av: got %b want 0", action_valid); end
    endtask

    task automatic test_motion();
        send(8'h07);
        n_cmp++; if (action !== 4'h4 || action_valid !== 1'b1) begin n_bad++; $display("FAIL turn_left: got act=%h av=%b want 4 1", action, action_valid); end
        step();
        n_cmp++; if (action_valid !== 1'b0) begin n_bad++; $display("FAIL av_one_cycle: got %b want 0", action_valid); end
        send(8'h07);
        n_cmp++; if (action !== 4'h4 || action_valid !== 1'b0) begin n_bad++; $display("FAIL same_action: got act=%h av=%b want 4 0", action, action_valid); end
        send(8'h16);
        n_cmp++; if (action !== 4'h6) begin n_bad++; $display("FAIL sturn_left: got %h want 6", action); end
        send(8'h19);
        n_cmp++; if (action !== 4'hA) begin n_bad++; $display("FAIL retreat: got %h want A", action); end
        send(8'h15);
        n_cmp++; if (action !== 4'hF || action_valid !== 1'b1) begin n_bad++; $display("FAIL stop: got act=%h av=%b want F 1", action, action_valid); end
    endtask

    task automatic test_mode_gate();
        send(8'h52);
        n_cmp++; if (mini_car_mode !== 2'b01 || action !== 4'hF) begin n_bad++; $display("FAIL mode_auto_a: got mode=%b act=%h want 01 F", mini_car_mode, action); end
        send(8'h07);
        send(8'h0C);
        n_cmp++; if (action !== 4'hF || action_valid !== 1'b0 || speed !== 2'd2 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL auto_ignore: got act=%h av=%b spd=%0d err=%0d want F 0 2 0", action, action_valid, speed, err_cnt); end
        send(8'h4A);
        n_cmp++; if (mini_car_mode !== 2'b10) begin n_bad++; $display("FAIL mode_auto_b: got %b want 10", mini_car_mode); end
        send(8'h42);
        n_cmp++; if (mini_car_mode !== 2'b00) begin n_bad++; $display("FAIL mode_manual: got %b want 00", mini_car_mode); end
        // Leaving manual while moving forces Stop.
        send(8'h40);
        send(8'h52);
        n_cmp++; if (action !== 4'hF || action_valid !== 1'b1 || mini_car_mode !== 2'b01) begin n_bad++; $display("FAIL leave_manual: got act=%h av=%b mode=%b want F 1 01", action, action_valid, mini_car_mode); end
        send(8'h42);
    endtask

    task automatic test_watchdog();
        send(8'h40);
        n_cmp++; if (action !== 4'h2 || action_valid !== 1'b1) begin n_bad++; $display("FAIL wd_start: got act=%h av=%b want 2 1", action, action_valid); end
        for (int i = 1; i < HOLD; i++) begin
            step();
            n_cmp++; if (action !== 4'h2 || timeout !== 1'b0) begin n_bad++; $display("FAIL wd_hold_%0d: got act=%h to=%b want 2 0", i, action, timeout); end
        end
        step();
        n_cmp++; if (action !== 4'hF || timeout !== 1'b1 || action_valid !== 1'b1) begin n_bad++; $display("FAIL wd_expire: got act=%h to=%b av=%b want F 1 1", action, timeout, action_valid); end
        step();
        n_cmp++; if (timeout !== 1'b0 || action !== 4'hF) begin n_bad++; $display("FAIL wd_pulse_end: got to=%b act=%h want 0 F", timeout, action); end
    endtask

    task automatic test_repeat();
        send(8'h40);
        for (int i = 0; i < 40; i++) begin
            frame_repeat = (i % 10 == 9);
            step();
            frame_repeat = 1'b0;
            n_cmp++; if (action !== 4'h2 || timeout !== 1'b0 || action_valid !== 1'b0) begin n_bad++; $display("FAIL repeat_hold_%0d: got act=%h to=%b av=%b want 2 0 0", i, action, timeout, action_valid); end
        end
        send(8'h15);
    endtask

    task automatic test_speed();
        for (int i = 0; i < 3; i++) begin
            send(8'h0C);
            n_cmp++; if (speed !== 2'd3) begin n_bad++; $display("FAIL speed_up_%0d: got %0d want 3", i, speed); end
        end
        for (int i = 0; i < 5; i++) begin
            send(8'h18);
            n_cmp++; if (speed !== ((i < 3) ? 2'(2 - i) : 2'd0)) begin n_bad++; $display("FAIL speed_dn_%0d: got %0d want %0d", i, speed, (i < 3) ? 2 - i : 0); end
        end
    endtask

    task automatic test_errors();
        send(8'h07);
        send(8'h00);
        n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL err_first: got %0d want 1", err_cnt); end
        send(8'hAB);
        n_cmp++; if (err_cnt !== 8'd2 || action !== 4'h4 || action_valid !== 1'b0) begin n_bad++; $display("FAIL err_second: got err=%0d act=%h av=%b want 2 4 0", err_cnt, action, action_valid); end
        send(8'h15);
    endtask

    task automatic test_simultaneous();
        frame_repeat = 1'b1;
        send(8'h09);
        frame_repeat = 1'b0;
        n_cmp++; if (action !== 4'h5 || action_valid !== 1'b1) begin n_bad++; $display("FAIL valid_and_repeat: got act=%h av=%b want 5 1", action, action_valid); end
        send(8'h15);
    endtask

    task automatic test_expiry_strobe();
        send(8'h40);
        for (int i = 1; i < HOLD; i++) step();
        // Now in the expiry cycle: a repeat here must win.
        frame_repeat = 1'b1;
        step();
        frame_repeat = 1'b0;
        n_cmp++; if (action !== 4'h2 || timeout !== 1'b0) begin n_bad++; $display("FAIL expiry_repeat: got act=%h to=%b want 2 0", action, timeout); end
        for (int i = 1; i < HOLD; i++) step();
        // Expiry cycle again: a valid command applies instead of the timeout.
        send(8'h07);
        n_cmp++; if (action !== 4'h4 || timeout !== 1'b0 || action_valid !== 1'b1) begin n_bad++; $display("FAIL expiry_valid: got act=%h to=%b av=%b want 4 0 1", action, timeout, action_valid); end
        send(8'h15);
    endtask

    task automatic test_reset_mid();
        send(8'h0C);
        send(8'h44);
        n_cmp++; if (action !== 4'h9) begin n_bad++; $display("FAIL rev_right: got %h want 9", action); end
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        frame_data = 8'h07;
        frame_valid = 1'b1;
        step();
        rst = 1'b0;
        frame_valid = 1'b0;
        n_cmp++; if (action !== 4'hF || mini_car_mode !== 2'b11 || speed !== 2'd2) begin n_bad++; $display("FAIL mid_reset_state: got act=%h mode=%b spd=%0d want F 11 2", action, mini_car_mode, speed); end
        n_cmp++; if (action_valid !== 1'b0 || timeout !== 1'b0 || err_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_reset_flags: got av=%b to=%b err=%0d want 0 0 0", action_valid, timeout, err_cnt); end
        step();
        n_cmp++; if (action !== 4'hF || mini_car_mode !== 2'b11) begin n_bad++; $display("FAIL post_reset: got act=%h mode=%b want F 11", action, mini_car_mode); end
    endtask

    initial begin
        test_reset();
        test_power();
        test_motion();
        test_mode_gate();
        test_watchdog();
        test_repeat();
        test_speed();
        test_errors();
        test_simultaneous();
        test_expiry_strobe();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
